// File: rtl/ofs_plat_prim_port_reset_sequencer_if.sv
// Port-facing signal bundle for the per-port soft reset sequencer.
// master drives the soft reset requests and stat_clear; slave is the sequencer.
interface ofs_plat_prim_port_reset_sequencer_if #(
  parameter int NUM_PORTS = 1
);
  logic [NUM_PORTS-1:0]    port_reset_req_n;
  logic                    stat_clear;
  logic [NUM_PORTS-1:0]    port_reset_n;
  logic                    all_ports_ready;
  logic                    any_pending;
  logic [NUM_PORTS*16-1:0] reset_event_cnt;

  modport master (
    output port_reset_req_n,
    output stat_clear,
    input  port_reset_n,
    input  all_ports_ready,
    input  any_pending,
    input  reset_event_cnt
  );

  modport slave (
    input  port_reset_req_n,
    input  stat_clear,
    output port_reset_n,
    output all_ports_ready,
    output any_pending,
    output reset_event_cnt
  );
endinterface

// File: rtl/ofs_plat_prim_port_reset_sequencer.sv
// Per-port soft reset sequencer: sync, stretch to a minimum width, stagger releases.
// Optional per-port RUN->ASSERT event counters are built when OFS_PLAT_RESET_SEQ_STATS_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ASSERT | port held in reset, minimum-width counter running/expired
// ST_PEND   | width satisfied, request released, waiting for a grant
// ST_RUN    | port out of reset
module ofs_plat_prim_port_reset_sequencer #(
  parameter int NUM_PORTS         = 1,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int RELEASE_STAGGER   = 4,
  parameter int SYNC_STAGES       = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  ofs_plat_prim_port_reset_sequencer_if.slave rst_if
);

  localparam int CW = (MIN_ASSERT_CYCLES > 1) ? $clog2(MIN_ASSERT_CYCLES) : 1;
  localparam int SW = (RELEASE_STAGGER > 1) ? $clog2(RELEASE_STAGGER) : 1;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [SW-1:0] STG_RELOAD = SW'(RELEASE_STAGGER - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_PEND   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  logic [NUM_PORTS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PORTS-1:0] req_s;

  state_e               state_q [NUM_PORTS];
  state_e               state_d [NUM_PORTS];
  logic [CW-1:0]        cnt_q   [NUM_PORTS];
  logic [CW-1:0]        cnt_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] run_exit;
  logic [NUM_PORTS-1:0] pend_d;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_vld;
  logic [PW-1:0]        grant_idx;
  int                   arb_idx;

  logic [SW-1:0]        stg_q, stg_d;
  logic [PW-1:0]        rr_q, rr_d;

  logic [NUM_PORTS-1:0] port_reset_n_q;
  logic                 any_pending_q;

  // Synchroniser flops reset to 0 so every port starts with its request asserted.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= rst_if.port_reset_req_n;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = req_s[p] &&
                    (((state_q[p] == ST_ASSERT) && (cnt_q[p] == '0)) ||
                     (state_q[p] == ST_PEND));
    end
  end

  // Round-robin search starting at rr_q, at most one grant per cycle.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    if (stg_q == '0) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        arb_idx = int'(rr_q) + i;
        if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
        if (!grant_vld && eligible[arb_idx]) begin
          grant_vld        = 1'b1;
          grant[arb_idx]   = 1'b1;
          grant_idx        = PW'(arb_idx);
        end
      end
    end
  end

  always_comb begin
    stg_d = stg_q;
    rr_d  = rr_q;
    if (grant_vld) begin
      stg_d = STG_RELOAD;
      rr_d  = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PW'(1);
    end else if (stg_q != '0) begin
      stg_d = stg_q - SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stg_q <= '0;
      rr_q  <= '0;
    end else begin
      stg_q <= stg_d;
      rr_q  <= rr_d;
    end
  end

  always_comb begin
    run_exit = '0;
    pend_d   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      case (state_q[p])
        ST_ASSERT: begin
          if (cnt_q[p] != '0) begin
            cnt_d[p] = cnt_q[p] - CW'(1);
          end else if (req_s[p]) begin
            state_d[p] = grant[p] ? ST_RUN : ST_PEND;
          end
        end
        ST_PEND: begin
          if (!req_s[p]) begin
            state_d[p] = ST_ASSERT;
            cnt_d[p]   = CNT_RELOAD;
          end else if (grant[p]) begin
            state_d[p] = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!req_s[p]) begin
            state_d[p]  = ST_ASSERT;
            cnt_d[p]    = CNT_RELOAD;
            run_exit[p] = 1'b1;
          end
        end
        default: begin
          state_d[p] = ST_ASSERT;
          cnt_d[p]   = CNT_RELOAD;
        end
      endcase
      pend_d[p] = (state_d[p] == ST_PEND);
    end
  end

  // Outputs are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= ST_ASSERT;
        cnt_q[p]   <= CNT_RELOAD;
      end
      port_reset_n_q <= '0;
      any_pending_q  <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p]        <= state_d[p];
        cnt_q[p]          <= cnt_d[p];
        port_reset_n_q[p] <= (state_d[p] == ST_RUN);
      end
      any_pending_q <= |pend_d;
    end
  end

  assign rst_if.port_reset_n    = port_reset_n_q;
  assign rst_if.all_ports_ready = &port_reset_n_q;
  assign rst_if.any_pending     = any_pending_q;

`ifdef OFS_PLAT_RESET_SEQ_STATS_EN
  logic [15:0] evt_q [NUM_PORTS];
  logic [15:0] evt_d [NUM_PORTS];

  // Clear wins over a coincident increment; counters saturate.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      evt_d[p] = evt_q[p];
      if (rst_if.stat_clear) begin
        evt_d[p] = '0;
      end else if (run_exit[p] && (evt_q[p] != 16'hFFFF)) begin
        evt_d[p] = evt_q[p] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int p = 0; p < NUM_PORTS; p++) evt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) evt_q[p] <= evt_d[p];
    end
  end

  always_comb begin
    rst_if.reset_event_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rst_if.reset_event_cnt[16*p +: 16] = evt_q[p];
    end
  end
`else
  logic unused_stats;
  assign unused_stats = rst_if.stat_clear ^ (|run_exit);
  assign rst_if.reset_event_cnt = '0;
`endif

endmodule

// File: tb/tb_ofs_plat_prim_port_reset_sequencer.sv
// Bench for the port reset sequencer: directed timing scenarios plus random
// request traffic compared against a timestamp-based reference model.
module tb_ofs_plat_prim_port_reset_sequencer;

  localparam int N   = 4;
  localparam int MIN = 16;
  localparam int STG = 4;
  localparam int SS  = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  ofs_plat_prim_port_reset_sequencer_if #(.NUM_PORTS(N)) dut_if ();

  ofs_plat_prim_port_reset_sequencer #(
    .NUM_PORTS        (N),
    .MIN_ASSERT_CYCLES(MIN),
    .RELEASE_STAGGER  (STG),
    .SYNC_STAGES      (SS)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .rst_if   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each port remembers the edge it last entered reset and
  // whether it is waiting for a grant; releases are timed from the last grant.
  logic [N-1:0] m_high, m_pend;
  int           m_a   [N];
  int           m_cnt [N];
  logic [N-1:0] m_hist [SS];
  int           m_n, m_lastg, m_rr;

  task automatic model_step();
    logic [N-1:0] rs, elig, nh, np;
    int na [N];
    int nc [N];
    int g, n, idx;
    n    = m_n + 1;
    rs   = m_hist[SS-1];
    nh   = m_high;
    np   = m_pend;
    elig = '0;
    for (int p = 0; p < N; p++) begin
      na[p] = m_a[p];
      nc[p] = m_cnt[p];
      if (m_high[p]) begin
        if (!rs[p]) begin
          nh[p] = 1'b0;
          na[p] = n;
          if (nc[p] < 65535) nc[p] = nc[p] + 1;
        end
      end else if (m_pend[p] && !rs[p]) begin
        np[p] = 1'b0;
        na[p] = n;
      end else if (rs[p] && (n >= m_a[p] + MIN)) begin
        elig[p] = 1'b1;
      end
    end
    g = -1;
    if (n >= m_lastg + STG) begin
      for (int i = 0; i < N; i++) begin
        idx = (m_rr + i) % N;
        if (g < 0 && elig[idx]) g = idx;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (elig[p]) begin
        if (p == g) begin
          nh[p] = 1'b1;
          np[p] = 1'b0;
        end else begin
          np[p] = 1'b1;
        end
      end
    end
    if (dut_if.stat_clear) for (int p = 0; p < N; p++) nc[p] = 0;
    m_high <= nh;
    m_pend <= np;
    m_n    <= n;
    for (int p = 0; p < N; p++) begin
      m_a[p]   <= na[p];
      m_cnt[p] <= nc[p];
    end
    if (g >= 0) begin
      m_lastg <= n;
      m_rr    <= (g + 1) % N;
    end
    m_hist[0] <= dut_if.port_reset_req_n;
    for (int s = 1; s < SS; s++) m_hist[s] <= m_hist[s-1];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_high  <= '0;
      m_pend  <= '0;
      m_n     <= 0;
      m_lastg <= -STG;
      m_rr    <= 0;
      for (int p = 0; p < N; p++) begin
        m_a[p]   <= 0;
        m_cnt[p] <= 0;
      end
      for (int s = 0; s < SS; s++) m_hist[s] <= '0;
    end else begin
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dut_if.port_reset_req_n = '1;
    dut_if.stat_clear = 1'b0;
    #2;
    n_cmp++;
    if (dut_if.port_reset_n !== '0 || dut_if.all_ports_ready !== 1'b0 ||
        dut_if.any_pending !== 1'b0 || dut_if.reset_event_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_values prn=%b rdy=%b pend=%b cnt=%h required 0000/0/0/0",
               dut_if.port_reset_n, dut_if.all_ports_ready, dut_if.any_pending,
               dut_if.reset_event_cnt);
    end
    @(negedge clk);
    tick();
    tick();
  endtask

  // Called at a negedge with rst_n low; releases reset and checks the stagger.
  task automatic test_powerup();
    logic [N-1:0] exp_v;
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      for (int p = 0; p < N; p++) exp_v[p] = (k >= MIN + STG * p);
      n_cmp++;
      if (dut_if.port_reset_n !== exp_v || dut_if.all_ports_ready !== (k >= 28) ||
          dut_if.any_pending !== (k >= 16 && k < 28)) begin
        n_fail++;
        $display("FAIL powerup k=%0d prn=%b rdy=%b pend=%b required %b/%b/%b", k,
                 dut_if.port_reset_n, dut_if.all_ports_ready, dut_if.any_pending,
                 exp_v, (k >= 28), (k >= 16 && k < 28));
      end
    end
  endtask

  task automatic test_pulse();
    logic [N-1:0] exp_v;
    repeat (4) tick();
    dut_if.port_reset_req_n[2] = 1'b0;
    tick();
    dut_if.port_reset_req_n[2] = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      exp_v    = '1;
      exp_v[2] = !(k >= 2 && k < 18);
      n_cmp++;
      if (dut_if.port_reset_n !== exp_v) begin
        n_fail++;
        $display("FAIL pulse k=%0d prn=%b required %b", k, dut_if.port_reset_n, exp_v);
      end
    end
  endtask

  task automatic test_long_request();
    logic [N-1:0] exp_v;
    repeat (4) tick();
    dut_if.port_reset_req_n[1] = 1'b0;
    repeat (40) tick();
    n_cmp++;
    if (dut_if.port_reset_n !== 4'b1101) begin
      n_fail++;
      $display("FAIL long_held prn=%b required 1101", dut_if.port_reset_n);
    end
    dut_if.port_reset_req_n[1] = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      tick();
      exp_v = (k >= 2) ? 4'b1111 : 4'b1101;
      n_cmp++;
      if (dut_if.port_reset_n !== exp_v) begin
        n_fail++;
        $display("FAIL long_release k=%0d prn=%b required %b", k, dut_if.port_reset_n, exp_v);
      end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_v;
    logic         ok;
    repeat (4) tick();
    // A lone port 3 release leaves the round-robin pointer at 0.
    dut_if.port_reset_req_n[3] = 1'b0;
    tick();
    dut_if.port_reset_req_n[3] = 1'b1;
    repeat (3) tick();
    ok = 1'b0;
    for (int w = 0; w < 40 && !ok; w++) begin
      tick();
      if (dut_if.port_reset_n[3] === 1'b1) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL contention_setup port3 release timed out, prn=%b required 1111",
               dut_if.port_reset_n);
    end
    repeat (4) tick();
    dut_if.port_reset_req_n[0] = 1'b0;
    dut_if.port_reset_req_n[3] = 1'b0;
    tick();
    dut_if.port_reset_req_n[0] = 1'b1;
    dut_if.port_reset_req_n[3] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_v    = 4'b0110;
      exp_v[0] = !(k >= 2 && k < 18);
      exp_v[3] = !(k >= 2 && k < 22);
      n_cmp++;
      if (dut_if.port_reset_n !== exp_v || dut_if.any_pending !== (k >= 18 && k <= 21)) begin
        n_fail++;
        $display("FAIL contention k=%0d prn=%b pend=%b required %b/%b", k,
                 dut_if.port_reset_n, dut_if.any_pending, exp_v, (k >= 18 && k <= 21));
      end
    end
  endtask

  task automatic test_reassert_pending();
    logic [N-1:0] exp_v;
    repeat (4) tick();
    dut_if.port_reset_req_n[0] = 1'b0;
    dut_if.port_reset_req_n[3] = 1'b0;
    tick();
    dut_if.port_reset_req_n[0] = 1'b1;
    dut_if.port_reset_req_n[3] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_v    = 4'b0110;
      exp_v[0] = !(k >= 2 && k < 18);
      exp_v[3] = (k < 2) || (k >= 37);
      n_cmp++;
      if (dut_if.port_reset_n !== exp_v || dut_if.any_pending !== (k >= 18 && k <= 20)) begin
        n_fail++;
        $display("FAIL reassert k=%0d prn=%b pend=%b required %b/%b", k,
                 dut_if.port_reset_n, dut_if.any_pending, exp_v, (k >= 18 && k <= 20));
      end
      if (k == 18) dut_if.port_reset_req_n[3] = 1'b0;
      if (k == 19) dut_if.port_reset_req_n[3] = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (22) tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_if.port_reset_n !== '0 || dut_if.all_ports_ready !== 1'b0 ||
        dut_if.any_pending !== 1'b0 || dut_if.reset_event_cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_reset prn=%b rdy=%b pend=%b cnt=%h required 0000/0/0/0",
               dut_if.port_reset_n, dut_if.all_ports_ready, dut_if.any_pending,
               dut_if.reset_event_cnt);
    end
    @(negedge clk);
    tick();
    test_powerup();
  endtask

  task automatic test_stats();
    logic        ok;
    logic [15:0] exp3;
`ifdef OFS_PLAT_RESET_SEQ_STATS_EN
    exp3 = 16'd3;
`else
    exp3 = 16'd0;
`endif
    repeat (4) tick();
    for (int j = 0; j < 3; j++) begin
      dut_if.port_reset_req_n[0] = 1'b0;
      tick();
      dut_if.port_reset_req_n[0] = 1'b1;
      repeat (3) tick();
      ok = 1'b0;
      for (int w = 0; w < 40 && !ok; w++) begin
        tick();
        if (dut_if.port_reset_n[0] === 1'b1) ok = 1'b1;
      end
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL stats_wait pulse=%0d prn=%b required 1111", j, dut_if.port_reset_n);
      end
      repeat (4) tick();
    end
    n_cmp++;
    if (dut_if.reset_event_cnt !== {48'h0, exp3}) begin
      n_fail++;
      $display("FAIL stats_count cnt=%h required %h", dut_if.reset_event_cnt, {48'h0, exp3});
    end
    dut_if.stat_clear = 1'b1;
    tick();
    dut_if.stat_clear = 1'b0;
    n_cmp++;
    if (dut_if.reset_event_cnt !== '0) begin
      n_fail++;
      $display("FAIL stats_clear cnt=%h required 0", dut_if.reset_event_cnt);
    end
    // stat_clear landing on the same edge as the RUN->ASSERT transition.
    dut_if.port_reset_req_n[0] = 1'b0;
    tick();
    dut_if.port_reset_req_n[0] = 1'b1;
    tick();
    dut_if.stat_clear = 1'b1;
    tick();
    dut_if.stat_clear = 1'b0;
    n_cmp++;
    if (dut_if.port_reset_n[0] !== 1'b0 || dut_if.reset_event_cnt !== '0) begin
      n_fail++;
      $display("FAIL stats_clear_vs_incr prn0=%b cnt=%h required 0/0",
               dut_if.port_reset_n[0], dut_if.reset_event_cnt);
    end
    repeat (30) tick();
  endtask

  task automatic test_random();
    logic [15:0] exp_c;
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 23) == 0)
          dut_if.port_reset_req_n[p] = ~dut_if.port_reset_req_n[p];
      end
      dut_if.stat_clear = ($urandom_range(0, 49) == 0);
      if (c == 1000) begin
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
      end
      tick();
      n_cmp++;
      if (dut_if.port_reset_n !== m_high || dut_if.all_ports_ready !== (&m_high) ||
          dut_if.any_pending !== (|m_pend)) begin
        n_fail++;
        $display("FAIL random c=%0d prn=%b rdy=%b pend=%b required %b/%b/%b", c,
                 dut_if.port_reset_n, dut_if.all_ports_ready, dut_if.any_pending,
                 m_high, &m_high, |m_pend);
      end
      for (int p = 0; p < N; p++) begin
`ifdef OFS_PLAT_RESET_SEQ_STATS_EN
        exp_c = 16'(m_cnt[p]);
`else
        exp_c = 16'd0;
`endif
        n_cmp++;
        if (dut_if.reset_event_cnt[16*p +: 16] !== exp_c) begin
          n_fail++;
          $display("FAIL random_cnt c=%0d port=%0d cnt=%h required %h", c, p,
                   dut_if.reset_event_cnt[16*p +: 16], exp_c);
        end
      end
    end
    dut_if.stat_clear = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_powerup();
    test_pulse();
    test_long_request();
    test_contention();
    test_reassert_pending();
    test_mid_reset();
    test_stats();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ofs_plat_prim_port_reset_sequencer.md
# ofs_plat_prim_port_reset_sequencer

Per-port soft reset sequencer for the AFU clock domain, the parametrised next generation of the per-port reset fan-out. It takes NUM_PORTS asynchronous active-low soft reset requests and synchronises each one. Each port reset is stretched to a guaranteed minimum width. Releases are serialised so that at most one port leaves reset per RELEASE_STAGGER cycles, which limits inrush activity when many host channel ports come up together. It sits between the FIM per-port soft resets and the PIM clocks structure, driving the pClk-domain reset_n of each port.

## Interface
- NUM_PORTS, 1: number of host channel ports (1..64).
- MIN_ASSERT_CYCLES, 16: minimum low width of each port_reset_n, in cycles (>=1).
- RELEASE_STAGGER, 4: minimum spacing between consecutive port releases, in cycles (>=1).
- SYNC_STAGES, 2: synchroniser depth for port_reset_req_n (>=2).

- clk  in  1  port clock (pClk).
- reset_n  in  1  global reset; asynchronous, active-low.
- port_reset_req_n  in  NUM_PORTS  per-port soft reset request, active-low, asynchronous to clk.
- stat_clear  in  1  synchronous clear of the statistics counters.
- port_reset_n  out  NUM_PORTS  registered per-port reset, active-low.
- all_ports_ready  out  1  AND of all port_reset_n bits.
- any_pending  out  1  at least one port is in PEND.
- reset_event_cnt  out  NUM_PORTS*16  per-port reset event counters; port p occupies bits [16p+15:16p].

## Operation
- **Synchroniser:** each port_reset_req_n bit passes through SYNC_STAGES flops. While reset_n is low, the flops are forced to 0 (request asserted).
- **Per-port FSM states:**
  - ASSERT: port_reset_n=0; a counter of width $clog2(MIN_ASSERT_CYCLES) (minimum 1 bit) decrements to 0 and then holds.
  - PEND: port_reset_n=0; waiting for a release grant.
  - RUN: port_reset_n=1.
- **Transitions:**
  - ASSERT→RUN when counter==0, the synced request is high, and the port is granted in the same cycle.
  - ASSERT→PEND when counter==0, the synced request is high, and the port is not granted.
  - PEND→RUN on grant.
  - PEND→ASSERT when the synced request goes low; the counter reloads to MIN_ASSERT_CYCLES-1.
  - RUN→ASSERT when the synced request goes low; the counter reloads to MIN_ASSERT_CYCLES-1.
- **Release arbiter:** round-robin.
  - A grant is possible only when the stagger counter==0.
  - The arbiter picks the first eligible port at or above the rr pointer, wrapping around.
  - On a grant, the stagger counter loads RELEASE_STAGGER-1 and the pointer moves to granted+1 mod NUM_PORTS.
  - At most one grant is issued per cycle.
- **Global reset (asynchronous, mid-operation included):**
  - All port_reset_n go to 0 immediately.
  - All FSMs enter ASSERT with counter=MIN_ASSERT_CYCLES-1.
  - The stagger counter and rr pointer are cleared to 0, and the statistics counters are cleared.
- **Reset values:** port_reset_n=0, all_ports_ready=0, any_pending=0, reset_event_cnt=0.

## Timing
- **Assertion latency:** a request low first sampled at edge t gives port_reset_n=0 after edge t+SYNC_STAGES.
- **Minimum width:** port_reset_n stays low for at least MIN_ASSERT_CYCLES cycles. It stays low exactly that long if the request has already returned high and the port is granted immediately.
- **Deassertion latency:** a request high first sampled at edge r, with the counter already expired and no contention, gives port_reset_n=1 after edge r+SYNC_STAGES.
- **Glitches:** a request pulse of one cycle is captured and produces a full MIN_ASSERT_CYCLES reset.
- **Stagger:** releases of different ports are separated by at least RELEASE_STAGGER edges.
- **Output paths:** any_pending is registered together with the FSM state. all_ports_ready is combinational from the registered port_reset_n.

## Configuration
- OFS_PLAT_RESET_SEQ_STATS_EN defined:
  - Each port has a 16-bit counter that increments on every RUN→ASSERT transition and saturates at 0xFFFF.
  - stat_clear zeroes all counters. If stat_clear and an increment occur in the same cycle, the result is 0.
- OFS_PLAT_RESET_SEQ_STATS_EN undefined: no counter logic is built; reset_event_cnt is tied to 0 and stat_clear is ignored.

## Test plan
All scenarios use NUM_PORTS=4, MIN_ASSERT_CYCLES=16, RELEASE_STAGGER=4, SYNC_STAGES=2.

1. **Power-up stagger:** all requests held high, reset_n released → port_reset_n[0..3] rise after edges 16, 20, 24, 28 following reset_n deassertion; all_ports_ready rises with port 3.
2. **One-cycle pulse:** a one-cycle low pulse on port 2 sampled at edge t → port_reset_n[2] falls after edge t+2 and rises after edge t+18; ports 0, 1 and 3 are unaffected.
3. **Long request:** port 1 request held low for 40 cycles, high first sampled at edge r → port_reset_n[1] rises after edge r+2.
4. **Contention:** ports 0 and 3 become eligible on the same edge e with the rr pointer at 0 → port 0 released after edge e, port 3 after edge e+4; any_pending is high across edges e..e+3.
5. **Re-assertion and mid-operation reset:** port 3 request goes low again while it is in PEND → it returns to ASSERT and stays low for 16 further cycles. reset_n pulsed low mid-stagger → all outputs 0 immediately, followed by the full scenario-1 sequence.
6. **Statistics:** three request pulses on port 0 → reset_event_cnt[15:0]=3 with OFS_PLAT_RESET_SEQ_STATS_EN defined and 0 without it; stat_clear → 0.
